// File: rtl/toast_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and request legality helpers.
package toast_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Only meaningful for legal funct3: BU/HU share the size bits of B/H.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: pick the byte/half selected by the low
// address bits out of the read word and sign- or zero-extend it.
module lsu_load_align
  import toast_lsu_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rd_data >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = rd_data;
    endcase
  end

endmodule

// File: rtl/toast_lsu.sv
// Load/store unit driving a registered one-cycle-latency data memory.
// One request at a time; all outputs registered; faults never touch memory.
module toast_lsu
  import toast_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic              Req_we,
  input  logic [2:0]        Req_funct3,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [31:0]       Req_wdata,
  input  logic [TAG_W-1:0]  Req_tag,
  output logic              Rsp_valid,
  output logic [31:0]       Rsp_data,
  output logic [TAG_W-1:0]  Rsp_tag,
  output logic              Fault_misaligned,
  output logic              Fault_illegal,
  output logic [ADDR_W-1:0] DMEM_addr,
  output logic [31:0]       DMEM_wr_data,
  output logic [3:0]        DMEM_wr_byte_en,
  output logic              DMEM_wr_en,
  output logic              DMEM_rst,
  input  logic [31:0]       DMEM_rd_data
);

  lsu_state_t       state, next_state;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       alo_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept, illegal, misaligned, go;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      load_result;

  assign accept     = Req_valid & Req_ready;
  assign illegal    = f3_illegal(Req_we, Req_funct3);
  assign misaligned = !illegal && f3_misaligned(Req_funct3, Req_addr[1:0]);
  assign go         = accept && !illegal && !misaligned;

  always_comb begin
    st_be   = BE_W;
    st_data = Req_wdata;
    case (Req_funct3)
      F3_B: begin
        st_be   = BE_B0 << Req_addr[1:0];
        st_data = {4{Req_wdata[7:0]}};
      end
      F3_H: begin
        st_be   = Req_addr[1] ? BE_HHI : BE_HLO;
        st_data = {2{Req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .rd_data (DMEM_rd_data),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .result  (load_result)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go) next_state = ISSUE;
      ISSUE:   next_state = we_q ? IDLE : WAIT;
      WAIT:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Req_ready        <= 1'b0;
      Rsp_valid        <= 1'b0;
      Rsp_data         <= '0;
      Rsp_tag          <= '0;
      Fault_misaligned <= 1'b0;
      Fault_illegal    <= 1'b0;
      DMEM_addr        <= '0;
      DMEM_wr_data     <= '0;
      DMEM_wr_byte_en  <= '0;
      DMEM_wr_en       <= 1'b0;
      DMEM_rst         <= 1'b1;
      we_q             <= 1'b0;
      f3_q             <= '0;
      alo_q            <= '0;
      tag_q            <= '0;
    end else begin
      Req_ready        <= (next_state == IDLE);
      Fault_illegal    <= accept && illegal;
      Fault_misaligned <= accept && misaligned;
      Rsp_valid        <= (state == WAIT);
      DMEM_wr_en       <= 1'b0;
      DMEM_rst         <= 1'b1;
      if (go) begin
        DMEM_addr <= Req_addr;
        we_q      <= Req_we;
        f3_q      <= Req_funct3;
        alo_q     <= Req_addr[1:0];
        tag_q     <= Req_tag;
        if (Req_we) begin
          DMEM_wr_en      <= 1'b1;
          DMEM_wr_byte_en <= st_be;
          DMEM_wr_data    <= st_data;
        end else begin
          DMEM_rst <= 1'b0;
        end
      end
      // Read data is valid during WAIT; capture it for the RESP cycle.
      if (state == WAIT) begin
        Rsp_data <= load_result;
        Rsp_tag  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_toast_lsu.sv
// Scoreboard bench for toast_lsu with a behavioural registered data memory.
module tb_toast_lsu;
  import toast_lsu_pkg::*;

  localparam int K_RSP = 0, K_ST = 1, K_FLT = 2;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Req_valid, Req_ready, Req_we;
  logic [2:0]  Req_funct3;
  logic [31:0] Req_addr, Req_wdata;
  logic [4:0]  Req_tag;
  logic        Rsp_valid;
  logic [31:0] Rsp_data;
  logic [4:0]  Rsp_tag;
  logic        Fault_misaligned, Fault_illegal;
  logic [31:0] DMEM_addr, DMEM_wr_data, DMEM_rd_data;
  logic [3:0]  DMEM_wr_byte_en;
  logic        DMEM_wr_en, DMEM_rst;

  toast_lsu #(.ADDR_W(32), .TAG_W(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_we(Req_we),
    .Req_funct3(Req_funct3), .Req_addr(Req_addr), .Req_wdata(Req_wdata), .Req_tag(Req_tag),
    .Rsp_valid(Rsp_valid), .Rsp_data(Rsp_data), .Rsp_tag(Rsp_tag),
    .Fault_misaligned(Fault_misaligned), .Fault_illegal(Fault_illegal),
    .DMEM_addr(DMEM_addr), .DMEM_wr_data(DMEM_wr_data), .DMEM_wr_byte_en(DMEM_wr_byte_en),
    .DMEM_wr_en(DMEM_wr_en), .DMEM_rst(DMEM_rst), .DMEM_rd_data(DMEM_rd_data)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [0:255];
  always @(posedge Clk) begin
    if (DMEM_wr_en)
      for (int i = 0; i < 4; i++)
        if (DMEM_wr_byte_en[i]) mem[DMEM_addr[9:2]][8*i +: 8] <= DMEM_wr_data[8*i +: 8];
    DMEM_rd_data <= DMEM_rst ? 32'h0 : mem[DMEM_addr[9:2]];
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  exp_t rsp_q[$], st_q[$], flt_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every output event must match the oldest pending expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Rsp_valid) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: data %h tag %0d at cyc %0d", Rsp_data, Rsp_tag, cyc);
      end else begin
        e = rsp_q.pop_front();
        if (Rsp_data !== e.d || Rsp_tag !== e.tag || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp: got data %h tag %0d cyc %0d expected data %h tag %0d cyc %0d",
                   Rsp_data, Rsp_tag, cyc, e.d, e.tag, e.cyc);
        end
      end
    end
    if (DMEM_wr_en) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL store_unexpected: addr %h be %b at cyc %0d", DMEM_addr, DMEM_wr_byte_en, cyc);
      end else begin
        e = st_q.pop_front();
        if (DMEM_addr !== e.a || DMEM_wr_byte_en !== e.be || DMEM_wr_data !== e.d || cyc != e.cyc) begin
          errors++;
          $display("FAIL store: got addr %h be %b data %h cyc %0d expected addr %h be %b data %h cyc %0d",
                   DMEM_addr, DMEM_wr_byte_en, DMEM_wr_data, cyc, e.a, e.be, e.d, e.cyc);
        end
      end
    end
    if (Fault_misaligned || Fault_illegal) begin
      checks++;
      if (flt_q.size() == 0) begin
        errors++;
        $display("FAIL fault_unexpected: mis %b ill %b at cyc %0d", Fault_misaligned, Fault_illegal, cyc);
      end else begin
        e = flt_q.pop_front();
        if ({Fault_illegal, Fault_misaligned} !== e.d[1:0] || cyc != e.cyc) begin
          errors++;
          $display("FAIL fault: got ill/mis %b%b cyc %0d expected %b cyc %0d",
                   Fault_illegal, Fault_misaligned, cyc, e.d[1:0], e.cyc);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] tag, input int kind,
                       input logic [31:0] exp_d, input logic [3:0] exp_be, input bit hold,
                       output int acc);
    exp_t e;
    int n;
    n = 0;
    Req_valid = 1'b1; Req_we = we; Req_funct3 = f3;
    Req_addr = addr; Req_wdata = wdata; Req_tag = tag;
    while (!Req_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!Req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: Req_ready %b after %0d cycles", Req_ready, n);
      Req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e.a = addr; e.d = exp_d; e.be = exp_be; e.tag = tag;
    if (kind == K_RSP) begin e.cyc = acc + 2; rsp_q.push_back(e); end
    else if (kind == K_ST) begin e.cyc = acc; st_q.push_back(e); end
    else begin e.cyc = acc; flt_q.push_back(e); end
    @(posedge Clk);
    #1 if (!hold) Req_valid = 1'b0;
    @(negedge Clk);
  endtask

  int a0, a1, a2, n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h8081_F2F3;
    mem[1]   = 32'h5566_7788;
    mem[255] = 32'h1122_3344;
    Reset_n = 1'b0; Req_valid = 1'b0; Req_we = 1'b0; Req_funct3 = 3'b0;
    Req_addr = 32'h0; Req_wdata = 32'h0; Req_tag = 5'h0;

    repeat (2) @(negedge Clk);
    chk("reset_ready", {31'h0, Req_ready}, 32'h0);
    chk("reset_dmem_rst", {31'h0, DMEM_rst}, 32'h1);
    chk("reset_wr_en", {31'h0, DMEM_wr_en}, 32'h0);
    chk("reset_rsp_valid", {31'h0, Rsp_valid}, 32'h0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_reset", {31'h0, Req_ready}, 32'h1);

    // Load extraction
    issue(0, F3_B,  32'h2001, 0, 5'd1, K_RSP, 32'hFFFF_FFF2, 4'h0, 0, a0);
    issue(0, F3_BU, 32'h2003, 0, 5'd2, K_RSP, 32'h0000_0080, 4'h0, 0, a0);
    issue(0, F3_H,  32'h2002, 0, 5'd3, K_RSP, 32'hFFFF_8081, 4'h0, 0, a0);
    issue(0, F3_HU, 32'h2000, 0, 5'd4, K_RSP, 32'h0000_F2F3, 4'h0, 0, a0);

    // Stores and read-after-write
    issue(1, F3_B,  32'h2002, 32'h0000_00AB, 5'd0, K_ST, 32'hABAB_ABAB, 4'b0100, 0, a0);
    issue(0, F3_W,  32'h2000, 0, 5'd5, K_RSP, 32'h80AB_F2F3, 4'h0, 0, a0);
    issue(1, F3_H,  32'h2002, 32'h0000_1234, 5'd0, K_ST, 32'h1234_1234, 4'b1100, 0, a0);
    issue(0, F3_HU, 32'h2002, 0, 5'd6, K_RSP, 32'h0000_1234, 4'h0, 0, a0);

    // Faults
    repeat (4) @(negedge Clk);
    issue(0, F3_W, 32'h2002, 0, 5'd0, K_FLT, 32'h1, 4'h0, 0, a0);
    chk("mis_lw_dmem_rst", {31'h0, DMEM_rst}, 32'h1);
    chk("mis_lw_ready", {31'h0, Req_ready}, 32'h1);
    issue(1, F3_H, 32'h2001, 32'h5555, 5'd0, K_FLT, 32'h1, 4'h0, 0, a0);
    chk("mis_sh_wr_en", {31'h0, DMEM_wr_en}, 32'h0);
    chk("mis_sh_ready", {31'h0, Req_ready}, 32'h1);
    issue(0, 3'b011, 32'h2000, 0, 5'd0, K_FLT, 32'h2, 4'h0, 0, a0);
    issue(1, 3'b011, 32'h2001, 0, 5'd0, K_FLT, 32'h2, 4'h0, 0, a0);
    issue(0, 3'b110, 32'h2001, 0, 5'd0, K_FLT, 32'h2, 4'h0, 0, a0);

    // Back-to-back loads with Req_valid held
    issue(0, F3_W,  32'h2000, 0, 5'd10, K_RSP, 32'h1234_F2F3, 4'h0, 1, a0);
    chk("b2b_ready_low_issue", {31'h0, Req_ready}, 32'h0);
    issue(0, F3_B,  32'h2003, 0, 5'd11, K_RSP, 32'h0000_0012, 4'h0, 1, a1);
    issue(0, F3_BU, 32'h2000, 0, 5'd12, K_RSP, 32'h0000_00F3, 4'h0, 0, a2);
    chk("b2b_spacing_1", a1 - a0, 32'd4);
    chk("b2b_spacing_2", a2 - a1, 32'd4);

    // Top of address space
    issue(0, F3_W, 32'hFFFF_FFFC, 0, 5'd13, K_RSP, 32'h1122_3344, 4'h0, 0, a0);
    issue(1, F3_W, 32'hFFFF_FFF8, 32'hCAFE_F00D, 5'd0, K_ST, 32'hCAFE_F00D, 4'b1111, 0, a0);

    // Reset during store ISSUE
    issue(1, F3_W, 32'h2004, 32'hDEAD_BEEF, 5'd0, K_ST, 32'hDEAD_BEEF, 4'b1111, 0, a0);
    #2 Reset_n = 1'b0;
    #1 chk("abort_store_wr_en", {31'h0, DMEM_wr_en}, 32'h0);
    repeat (2) @(negedge Clk);
    chk("abort_store_mem", mem[1], 32'h5566_7788);
    chk("abort_ready_low", {31'h0, Req_ready}, 32'h0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset during load WAIT
    issue(0, F3_W, 32'h2000, 0, 5'd7, K_RSP, 32'h1234_F2F3, 4'h0, 0, a0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    rsp_q.delete();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_abort", {31'h0, Req_ready}, 32'h1);
    issue(0, F3_W, 32'h2000, 0, 5'd9, K_RSP, 32'h1234_F2F3, 4'h0, 0, a0);

    n = 0;
    while ((rsp_q.size() + st_q.size() + flt_q.size()) != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    repeat (6) @(negedge Clk);
    chk("pending_expectations", rsp_q.size() + st_q.size() + flt_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
